// File: rtl/pll_lock_monitor.sv
// PLL enable sequencer and lock monitor with a Wishbone register slave; optional IRQ via `PLL_LOCK_IRQ_EN.
// Latency: bus ack one cycle after request sample; lock/loss decided on the cycle a measurement window ends.
// Backpressure: none; a request is accepted once per ack, and a held strobe is not re-accepted while ack is high.
module pll_lock_monitor #(
    parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
    parameter int          CNT_W         = 16,
    parameter int          GATE_CYCLES   = 1024,
    parameter int          SETTLE_CYCLES = 256,
    parameter int          LOCK_NEED     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        pll_clk_i,
    output logic        enb_cp_o,
    output logic        enb_vco_o,
    output logic        lock_o,
    output logic        irq_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CP_ON   = 3'd1;
    localparam logic [2:0] S_VCO_ON  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;

    // One timer serves both the settle waits and the gate window; they never overlap.
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] tol_q, tol_d;
    logic [7:0]       run_q, run_d;
    logic             lost_q, lost_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             sync1_q, sync2_q, hist_q;

    // ---------------- bus decode ----------------
    logic        bus_req, bus_wr, bus_rd;
    logic        hit_ctrl, hit_target, hit_tol, hit_status;
    logic [31:0] wmask;
    logic        ctrl_start, ctrl_stop, lost_clr;

    assign bus_req    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~ack_q;
    assign bus_wr     = bus_req & wbs_we_i;
    assign bus_rd     = bus_req & ~wbs_we_i;
    assign hit_ctrl   = (wbs_adr_i[3:0] == 4'h0);
    assign hit_target = (wbs_adr_i[3:0] == 4'h4);
    assign hit_tol    = (wbs_adr_i[3:0] == 4'h8);
    assign hit_status = (wbs_adr_i[3:0] == 4'hC);
    assign wmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign ctrl_start = bus_wr & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
    assign ctrl_stop  = bus_wr & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
    assign lost_clr   = bus_wr & hit_status & wbs_sel_i[0] & wbs_dat_i[4];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // ---------------- PLL edge detect ----------------
    logic             pll_edge;
    logic [CNT_W-1:0] edge_inc, win_count;
    logic [CNT_W:0]   diff, abs_diff;
    logic             win_good;
    logic [7:0]       run_inc;
    logic             lost_set;

    assign pll_edge  = sync2_q & ~hist_q;
    assign edge_inc  = (edge_cnt_q == {CNT_W{1'b1}}) ? edge_cnt_q : edge_cnt_q + 1'b1;
    assign win_count = pll_edge ? edge_inc : edge_cnt_q;
    assign diff      = {1'b0, win_count} - {1'b0, target_q};
    assign abs_diff  = diff[CNT_W] ? (~diff + 1'b1) : diff;
    assign win_good  = (abs_diff <= {1'b0, tol_q});
    assign run_inc   = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

    // Synchronise the PLL clock and keep a history bit for rising-edge detection
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= pll_clk_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Sequencer / measurement FSM next state; STOP overrides everything
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        edge_cnt_d = edge_cnt_q;
        run_d      = run_q;
        last_d     = last_q;
        lost_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    state_d = S_CP_ON;
                    tmr_d   = '0;
                end
            end
            S_CP_ON: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_VCO_ON;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_VCO_ON: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d    = S_MEASURE;
                    tmr_d      = '0;
                    edge_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_MEASURE, S_LOCKED: begin
                if (tmr_q == TMR_W'(GATE_CYCLES - 1)) begin
                    // Window end: the next window begins on the very next cycle
                    last_d     = win_count;
                    tmr_d      = '0;
                    edge_cnt_d = '0;
                    if (win_good) begin
                        run_d = run_inc;
                        if (int'(run_inc) >= LOCK_NEED) state_d = S_LOCKED;
                    end else begin
                        run_d = 8'd0;
                        if (state_q == S_LOCKED) lost_set = 1'b1;
                        state_d = S_MEASURE;
                    end
                end else begin
                    tmr_d      = tmr_q + 1'b1;
                    edge_cnt_d = win_count;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
        if (ctrl_stop) begin
            state_d    = S_IDLE;
            tmr_d      = '0;
            edge_cnt_d = '0;
            run_d      = 8'd0;
        end
    end

    // Configuration register writes and sticky LOST (set beats clear)
    always_comb begin
        target_d = target_q;
        tol_d    = tol_q;
        if (bus_wr && hit_target) target_d = CNT_W'(merge_bytes(32'(target_q), wbs_dat_i, wmask));
        if (bus_wr && hit_tol)    tol_d    = CNT_W'(merge_bytes(32'(tol_q), wbs_dat_i, wmask));
        lost_d = lost_q;
        if (lost_clr) lost_d = 1'b0;
        if (lost_set) lost_d = 1'b1;
    end

    logic [31:0] ctrl_rd;
    logic [31:0] status_rd;
    assign status_rd = {16'(last_q), run_q, 3'b000, lost_q, (state_q == S_LOCKED), state_q};

`ifdef PLL_LOCK_IRQ_EN
    logic irq_q, irq_d, mask_q, mask_d;
    logic lock_rise;
    assign lock_rise = (state_d == S_LOCKED) && (state_q != S_LOCKED);
    assign ctrl_rd   = {29'd0, mask_q, 2'b00};
    assign irq_o     = irq_q & ~mask_q;

    // Interrupt level and mask next state; new events beat the clear
    always_comb begin
        mask_d = mask_q;
        if (bus_wr && hit_ctrl && wbs_sel_i[0]) mask_d = wbs_dat_i[2];
        irq_d = irq_q;
        if (lost_clr) irq_d = 1'b0;
        if (lock_rise || lost_set) irq_d = 1'b1;
    end

    // Interrupt state registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_q  <= 1'b0;
            mask_q <= 1'b0;
        end else begin
            irq_q  <= irq_d;
            mask_q <= mask_d;
        end
    end
`else
    assign ctrl_rd = 32'd0;
    assign irq_o   = 1'b0;
`endif

    // Single-cycle ack and read data returned alongside it
    always_comb begin
        ack_d = bus_req;
        dat_d = 32'd0;
        if (bus_rd) begin
            if (hit_ctrl)   dat_d = ctrl_rd;
            if (hit_target) dat_d = 32'(target_q);
            if (hit_tol)    dat_d = 32'(tol_q);
            if (hit_status) dat_d = status_rd;
        end
    end

    // Main state registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            edge_cnt_q <= '0;
            last_q     <= '0;
            target_q   <= '0;
            tol_q      <= '0;
            run_q      <= 8'd0;
            lost_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            edge_cnt_q <= edge_cnt_d;
            last_q     <= last_d;
            target_q   <= target_d;
            tol_q      <= tol_d;
            run_q      <= run_d;
            lost_q     <= lost_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign enb_cp_o  = ~((state_q == S_CP_ON) | (state_q == S_VCO_ON) |
                         (state_q == S_MEASURE) | (state_q == S_LOCKED));
    assign enb_vco_o = ~((state_q == S_VCO_ON) | (state_q == S_MEASURE) | (state_q == S_LOCKED));
    assign lock_o    = (state_q == S_LOCKED);

endmodule
